cegen_multi: RTL and testbench
==============================

// Module: cegen_multi
// PURPOSE
//  Parametrised multi-channel fractional clock-enable generator; successor to the fixed 5-output PLL wrapper.
//  Derives NUM_CH independent CE strobes (e.g. 12.09/6.05/3.02 MHz video/CPU rates) from one core clock via
//  phase accumulators, with glitch-free run-time retuning per channel and a lock indication for downstream cores.
// PARAMETERS
//  NUM_CH      5                     number of CE channels (1..16)
//  ACC_W       24                    phase-accumulator width; f_ce = f_refclk * inc / 2^ACC_W
//  INC_INIT    {NUM_CH*ACC_W{1'b0}}  flattened per-channel reset increments, ch0 in LSBs
//  LOCK_CYCLES 16                    cycles after reset before locked may assert (>=1)
// PORTS
//  refclk      in   1             core clock; all logic on rising edge
//  rst_n       in   1             asynchronous, active-low reset
//  cfg_valid   in   1             retune request valid
//  cfg_ready   out  1             retune slot free; transfer on cfg_valid & cfg_ready
//  cfg_ch      in   $clog2(NUM_CH) target channel (>=NUM_CH: request accepted and discarded)
//  cfg_inc     in   ACC_W         new increment for cfg_ch
//  sync_req    in   1             (CEGEN_SYNC_EN only) zero all accumulators
//  ce_out      out  NUM_CH        one-cycle CE strobes, registered
//  locked      out  1             warm-up complete and no retune pending
// BEHAVIOUR
//  - Reset: acc=0, inc=INC_INIT, ce_out=0, locked=0, cfg_ready=0, lock counter=0, FSM=WARM.
//  - Per channel each cycle: {c,acc_nxt} = acc + inc (ACC_W+1 bits); acc<=acc_nxt; ce_out[i]<=c. Latency 1 cycle.
//  - inc=0: channel never strobes. inc=2^ACC_W-1: strobes every cycle except one per 2^ACC_W. No wider math.
//  - FSM WARM: count to LOCK_CYCLES-1, cfg_ready=0; -> RUN (locked=1 first cycle of RUN, cycle LOCK_CYCLES after release).
//  - RUN: cfg_ready=1. On accept: latch ch/inc into pending reg -> PEND (locked=0, cfg_ready=0 next cycle).
//  - PEND: apply pending inc on the cycle target channel produces carry (strobe still emitted with old inc;
//    new inc used from next add), acc not cleared -> RUN. If current inc of target is 0, apply next cycle.
//  - Invalid cfg_ch: accepted, no PEND, stays RUN, locked unaffected.
//  - Only one retune in flight; cfg_valid while cfg_ready=0 is held off, never lost by this block.
//  - Reset mid-PEND: pending request discarded, inc returns to INC_INIT.
//  - Channels run independently; no inter-channel phase relation guaranteed without CEGEN_SYNC_EN.
// CONFIGURATION
//  - Macro CEGEN_SYNC_EN defined: sync_req port present; sync_req=1 forces all acc<=0 and ce_out<=0 next cycle,
//    overriding add; pending retune in PEND is applied immediately in the same cycle; locked unchanged.
//    Gives phase-aligned strobes (divide-by-2 chains line up as a ripple divider).
//  - Undefined: no sync_req port, no sync logic; accumulators free-running from reset.
// STRUCTURE
//  - Package cegen_pkg: state_t enum {WARM,RUN,PEND}; CEGEN_ACC_W_DEF=24;
//    function inc_for(f_out_hz, f_ref_hz, acc_w) for elaboration-time INC_INIT.
//  - Sub-module cegen_acc (one channel: acc, inc reg, load strobe, carry->ce), instantiated NUM_CH times by generate.
//  - Top holds FSM, lock counter, pending register, cfg handshake, sync fan-out.
// TESTING
//  1 Reset: rst_n low 5 cycles, INC_INIT ch0=0x800000 -> ce_out=0, locked=0; locked=1 exactly 16 cycles after release.
//  2 Rates: ACC_W=24, incs 0x800000/0x400000/0x200000/0 -> ch0 every 2, ch1 every 4, ch2 every 8, ch3 never over 1024 cycles.
//  3 Retune: ch1 0x400000->0x800000 mid-run -> cfg_ready/locked low until ch1 next strobe; period 4 then 2, no runt pulse.
//  4 Zero-inc retune: ch3 inc 0 -> 0x100000 applied 1 cycle after accept; first strobe 16 cycles later.
//  5 Reset in PEND: accept ch0 retune, assert rst_n before ch0 carry -> ch0 resumes INC_INIT rate, cfg_ready=0 during warm-up.
//  6 CEGEN_SYNC_EN: pulse sync_req -> all ce_out=0 next cycle; ch0/ch1/ch2 strobes coincide every 8 cycles thereafter.

Source files
------------

// File: rtl/cegen_pkg.sv
// cegen_pkg: shared types, defaults and elaboration-time helpers for the
// multi-channel fractional clock-enable generator.
package cegen_pkg;

   // Control states: warm-up after reset, normal running, retune pending.
   typedef enum logic [1:0] {
      WARM = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int CEGEN_ACC_W_DEF = 24;

   // Increment giving f_out_hz from f_ref_hz with an acc_w-bit accumulator,
   // rounded to nearest. Intended for building INC_INIT at elaboration.
   function automatic longint unsigned inc_for(input longint unsigned f_out_hz,
                                               input longint unsigned f_ref_hz,
                                               input int unsigned     acc_w);
      longint unsigned num;
      if (f_ref_hz == 0) begin
         return 0;
      end
      num = f_out_hz << acc_w;
      return (num + (f_ref_hz >> 1)) / f_ref_hz;
   endfunction

endpackage

// File: rtl/cegen_acc.sv
// cegen_acc: one clock-enable channel. Phase accumulator plus increment
// register; the accumulator carry becomes a registered one-cycle CE strobe.
// The increment is swapped only when the parent asserts i_load.
module cegen_acc
   import cegen_pkg::*;
#(
   parameter int               ACC_W   = CEGEN_ACC_W_DEF,
   parameter logic [ACC_W-1:0] INC_RST = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sync,
   input  logic             i_load,
   input  logic [ACC_W-1:0] i_load_inc,
   output logic             o_ce,
   output logic             o_carry,
   output logic             o_inc_zero
);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_inc;
   logic             r_ce;
   logic [ACC_W:0]   w_sum;

   // One extra bit holds the carry; no wider arithmetic is needed.
   assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
   assign o_carry    = w_sum[ACC_W];
   assign o_inc_zero = (r_inc == '0);
   assign o_ce       = r_ce;

   // Phase accumulation and strobe; sync zeroes the phase and masks the strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc <= '0;
         r_ce  <= 1'b0;
      end else if (i_sync) begin
         r_acc <= '0;
         r_ce  <= 1'b0;
      end else begin
         r_acc <= w_sum[ACC_W-1:0];
         r_ce  <= w_sum[ACC_W];
      end
   end

   // Increment register: the new value takes effect from the following add.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inc <= INC_RST;
      end else if (i_load) begin
         r_inc <= i_load_inc;
      end
   end

endmodule

// File: rtl/cegen_multi.sv
// cegen_multi: NUM_CH independent fractional clock-enable strobes derived
// from refclk by phase accumulators, with a one-deep retune channel and a
// lock indication. Retunes are applied on the target's carry cycle so the
// strobe train never shows a runt or a missing pulse.
// Optional feature: define CEGEN_SYNC_EN to add the sync_req port, which
// zeroes every accumulator for phase-aligned strobes.
module cegen_multi
   import cegen_pkg::*;
#(
   parameter int                      NUM_CH      = 5,
   parameter int                      ACC_W       = CEGEN_ACC_W_DEF,
   parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = '0,
   parameter int                      LOCK_CYCLES = 16,
   localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst_n,
`ifdef CEGEN_SYNC_EN
   input  logic              sync_req,
`endif
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);

   localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CH_W-1:0]    r_pend_ch;
   logic [ACC_W-1:0]   r_pend_inc;

   logic               w_sync;
   logic               w_ch_ok;
   logic               w_take;
   logic               w_hit;
   logic [NUM_CH-1:0]  w_sel;
   logic [NUM_CH-1:0]  w_carry;
   logic [NUM_CH-1:0]  w_inc_zero;
   logic [NUM_CH-1:0]  w_load;
   logic [NUM_CH-1:0]  w_ce;

`ifdef CEGEN_SYNC_EN
   assign w_sync = sync_req;
`else
   assign w_sync = 1'b0;
`endif

   // Requests to channels that do not exist are consumed without effect.
   assign w_ch_ok = (32'(cfg_ch) < NUM_CH);
   assign w_take  = cfg_valid && (r_state == RUN) && w_ch_ok;

   // Apply point: target carries this cycle, target is idle (inc 0, would
   // never carry), or a sync is zeroing all phases anyway.
   assign w_hit  = (|(w_sel & (w_carry | w_inc_zero))) | w_sync;
   assign w_load = ((r_state == PEND) && w_hit) ? w_sel : '0;

   assign ce_out = w_ce;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_sel[g] = (r_pend_ch == CH_W'(g));

      cegen_acc #(
         .ACC_W   (ACC_W),
         .INC_RST (INC_INIT[g*ACC_W +: ACC_W])
      ) u_acc (
         .i_clk      (refclk),
         .i_rst_n    (rst_n),
         .i_sync     (w_sync),
         .i_load     (w_load[g]),
         .i_load_inc (r_pend_inc),
         .o_ce       (w_ce[g]),
         .o_carry    (w_carry[g]),
         .o_inc_zero (w_inc_zero[g])
      );
   end

   // Control state register.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WARM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake/lock outputs decoded from the current state.
   always_comb begin
      w_state_nxt = r_state;
      cfg_ready   = 1'b0;
      locked      = 1'b0;
      case (r_state)
         WARM: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            cfg_ready = 1'b1;
            locked    = 1'b1;
            if (cfg_valid && w_ch_ok) begin
               w_state_nxt = PEND;
            end
         end
         PEND: begin
            if (w_hit) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = WARM;
         end
      endcase
   end

   // Warm-up counter; saturates so it only needs clearing by reset.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if ((r_state == WARM) && (r_cnt != CNT_LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Pending retune register, captured on an accepted valid request.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_ch  <= '0;
         r_pend_inc <= '0;
      end else if (w_take) begin
         r_pend_ch  <= cfg_ch;
         r_pend_inc <= cfg_inc;
      end
   end

endmodule

// File: tb/tb_cegen_multi.sv
// tb_cegen_multi: bench for cegen_multi (5 channels, 24-bit accumulators).
// A behavioural model predicts outputs each clock into a scoreboard queue;
// directed sequences add explicit latency, rate and retune checks.
module tb_cegen_multi;

   localparam int NUM_CH = 5;
   localparam int ACC_W  = 24;
   localparam int LOCK   = 16;
   localparam logic [NUM_CH*ACC_W-1:0] INIT =
      {24'hFFFFFF, 24'h000000, 24'h200000, 24'h400000, 24'h800000};

   logic              refclk = 1'b0;
   logic              rst_n;
   logic              sync_req;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [2:0]        cfg_ch;
   logic [ACC_W-1:0]  cfg_inc;
   logic [NUM_CH-1:0] ce_out;
   logic              locked;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 refclk = ~refclk;

   cegen_multi #(
      .NUM_CH      (NUM_CH),
      .ACC_W       (ACC_W),
      .INC_INIT    (INIT),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
`ifdef CEGEN_SYNC_EN
      .sync_req  (sync_req),
`endif
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .ce_out    (ce_out),
      .locked    (locked)
   );

   // ---------------- reference model ----------------
   logic [ACC_W-1:0]  m_acc  [NUM_CH];
   logic [ACC_W-1:0]  m_inc  [NUM_CH];
   logic [ACC_W-1:0]  mn_acc [NUM_CH];
   logic [ACC_W-1:0]  mn_inc [NUM_CH];
   logic [ACC_W:0]    m_sum  [NUM_CH];
   logic [NUM_CH-1:0] mn_ce;
   int                m_state, mn_state, m_cnt, mn_cnt, m_pch, mn_pch;
   logic [ACC_W-1:0]  m_pinc, mn_pinc;
   logic [NUM_CH+1:0] sb [$];

   always_comb begin
      mn_acc   = m_acc;
      mn_inc   = m_inc;
      mn_state = m_state;
      mn_cnt   = m_cnt;
      mn_pch   = m_pch;
      mn_pinc  = m_pinc;
      mn_ce    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_sum[i]  = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
         mn_acc[i] = m_sum[i][ACC_W-1:0];
         mn_ce[i]  = m_sum[i][ACC_W];
      end
      if (sync_req) begin
         for (int i = 0; i < NUM_CH; i++) mn_acc[i] = '0;
         mn_ce = '0;
      end
      case (m_state)
         0: begin
            if (m_cnt == LOCK - 1) mn_state = 1;
            else mn_cnt = m_cnt + 1;
         end
         1: begin
            if (cfg_valid && (cfg_ch < NUM_CH)) begin
               mn_pch   = int'(cfg_ch);
               mn_pinc  = cfg_inc;
               mn_state = 2;
            end
         end
         default: begin
            if (m_sum[m_pch][ACC_W] || (m_inc[m_pch] == '0) || sync_req) begin
               mn_inc[m_pch] = m_pinc;
               mn_state      = 1;
            end
         end
      endcase
   end

   always @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] <= '0;
            m_inc[i] <= INIT[i*ACC_W +: ACC_W];
         end
         m_state <= 0;
         m_cnt   <= 0;
         m_pch   <= 0;
         m_pinc  <= '0;
         sb.delete();
      end else begin
         m_acc   <= mn_acc;
         m_inc   <= mn_inc;
         m_state <= mn_state;
         m_cnt   <= mn_cnt;
         m_pch   <= mn_pch;
         m_pinc  <= mn_pinc;
         sb.push_back({mn_ce, (mn_state == 1), (mn_state == 1)});
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock: inputs were set at the previous falling edge; outputs are
   // compared at the next falling edge.
   task automatic cyc();
      logic [NUM_CH+1:0] act;
      logic [NUM_CH+1:0] exp;
      @(posedge refclk);
      @(negedge refclk);
      act = {ce_out, locked, cfg_ready};
      if (!rst_n) begin
         chk("reset_outputs", 32'(act), 32'd0);
      end else if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_empty: got no prediction, expected one per cycle");
      end else begin
         exp = sb.pop_front();
         chk("cycle_{ce,locked,ready}", 32'(act), 32'(exp));
      end
   endtask

   task automatic send(input logic [2:0] ch, input logic [ACC_W-1:0] inc);
      int n;
      n         = 0;
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_inc   = inc;
      while (!cfg_ready && n < 64) begin
         cyc();
         n++;
      end
      if (!cfg_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: cfg_ready stayed %0b, expected 1", cfg_ready);
      end
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_lock(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!locked && n < 200);
   endtask

   task automatic next_strobe(input int ch, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!ce_out[ch] && n < 200);
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      int ch;
      int exp_cnt;
   } rate_t;

   typedef struct {
      logic [2:0]       ch;
      logic [ACC_W-1:0] inc;
      bit               pend;
   } cfg_t;

   initial begin
      rate_t rt [NUM_CH];
      cfg_t  ct [3];
      int    cnt [NUM_CH];
      int    n;
      int    aligned;

      rt = '{'{0, 512}, '{1, 256}, '{2, 128}, '{3, 0}, '{4, 1024}};
      ct = '{'{3'd6, 24'h123456, 1'b0},
             '{3'd7, 24'h000000, 1'b0},
             '{3'd2, 24'h200000, 1'b1}};

      rst_n     = 1'b0;
      sync_req  = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_inc   = '0;

      // Reset held for 5 cycles, then lock latency after release.
      repeat (5) cyc();
      rst_n = 1'b1;
      wait_lock(n);
      chk("lock_latency", n, LOCK);

      // Free-running rates over 1024 cycles.
      for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
      repeat (1024) begin
         cyc();
         for (int i = 0; i < NUM_CH; i++) cnt[i] += int'(ce_out[i]);
      end
      for (int k = 0; k < NUM_CH; k++)
         chk($sformatf("rate_ch%0d", rt[k].ch), cnt[rt[k].ch], rt[k].exp_cnt);

      // Retune request table: invalid channels never leave RUN.
      for (int k = 0; k < 3; k++) begin
         send(ct[k].ch, ct[k].inc);
         chk($sformatf("cfg%0d_locked_after_accept", k), 32'(locked), 32'(!ct[k].pend));
         if (ct[k].pend) begin
            wait_lock(n);
            chk($sformatf("cfg%0d_pend_within_period", k), 32'(n >= 1 && n <= 8), 32'd1);
            chk($sformatf("cfg%0d_apply_on_strobe", k), 32'(ce_out[ct[k].ch]), 32'd1);
         end
      end

      // Retune ch1 from period 4 to period 2 on its next strobe.
      send(3'd1, 24'h800000);
      chk("ch1_retune_unlocked", 32'(locked), 32'd0);
      wait_lock(n);
      chk("ch1_pend_within_period", 32'(n >= 1 && n <= 4), 32'd1);
      chk("ch1_strobe_at_relock", 32'(ce_out[1]), 32'd1);
      next_strobe(1, n);
      chk("ch1_new_period_a", n, 2);
      next_strobe(1, n);
      chk("ch1_new_period_b", n, 2);

      // Zero-increment channel: applied one cycle after accept.
      send(3'd3, 24'h100000);
      chk("ch3_pend_after_accept", 32'(locked), 32'd0);
      cyc();
      chk("ch3_applied_next_cycle", 32'(locked), 32'd1);
      next_strobe(3, n);
      chk("ch3_first_strobe", n, 16);

      // Reset while a ch0 retune is pending: retune is dropped.
      send(3'd0, 24'h400000);
      chk("ch0_pend_before_reset", 32'(locked), 32'd0);
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      wait_lock(n);
      chk("relock_latency", n, LOCK);
      for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
      repeat (64) begin
         cyc();
         for (int i = 0; i < NUM_CH; i++) cnt[i] += int'(ce_out[i]);
      end
      chk("ch0_init_rate_after_reset", cnt[0], 32);
      chk("ch1_init_rate_after_reset", cnt[1], 16);
      chk("ch3_init_rate_after_reset", cnt[3], 0);

`ifdef CEGEN_SYNC_EN
      // Sync pulse: strobes cleared, then ch0/ch1/ch2 coincide every 8 cycles.
      sync_req = 1'b1;
      cyc();
      sync_req = 1'b0;
      chk("sync_clears_ce", 32'(ce_out), 32'd0);
      next_strobe(2, n);
      chk("sync_first_ch2", n, 8);
      chk("sync_first_aligned", 32'(ce_out[1:0]), 32'd3);
      cnt[2]  = 0;
      aligned = 0;
      repeat (56) begin
         cyc();
         if (ce_out[2]) begin
            cnt[2]++;
            if (ce_out[1:0] == 2'b11) aligned++;
         end
      end
      chk("sync_ch2_count", cnt[2], 7);
      chk("sync_aligned_count", aligned, 7);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

endmodule
